async_counter: RTL and testbench

- WIDTH-bit up/down counter with a direction select, used as a general-purpose event/position counter.
- Named after the classic ripple structure. It is implemented fully synchronously in a single clock domain: per-bit toggle stages, with no derived clocks.
- Counts by one on every rising clock edge; wraps modulo 2^WIDTH in both directions.

---
 rtl/async_counter.sv | 57 +++++
 tb/tb_async_counter.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/async_counter.sv
// Up/down counter built from per-bit toggle stages, fully synchronous in one clock.
// Bit i flips when every lower bit is 1 (up) or 0 (down); bit 0 flips every cycle.
module async_counter_bit (
    input  logic clk,
    input  logic rst,
    input  logic tgl_i,
    output logic bit_o
);
    logic bit_q, bit_d;

    always_comb begin
        bit_d = bit_q ^ tgl_i;
    end

    always_ff @(posedge clk) begin
        if (rst) bit_q <= 1'b0;
        else     bit_q <= bit_d;
    end

    assign bit_o = bit_q;
endmodule

module async_counter #(
    parameter int WIDTH = 4
) (
    input  logic             up,
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] count
);
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] ones_pre;   // bits [i-1:0] all ones
    logic [WIDTH-1:0] zeros_pre;  // bits [i-1:0] all zeros
    logic [WIDTH-1:0] tgl;

    assign ones_pre[0]  = 1'b1;
    assign zeros_pre[0] = 1'b1;

    genvar i;
    generate
        for (i = 1; i < WIDTH; i++) begin : g_pre
            assign ones_pre[i]  = ones_pre[i-1]  &  cnt_q[i-1];
            assign zeros_pre[i] = zeros_pre[i-1] & ~cnt_q[i-1];
        end
        for (i = 0; i < WIDTH; i++) begin : g_bit
            assign tgl[i] = up ? ones_pre[i] : zeros_pre[i];
            async_counter_bit u_bit (
                .clk   (clk),
                .rst   (rst),
                .tgl_i (tgl[i]),
                .bit_o (cnt_q[i])
            );
        end
    endgenerate

    assign count = cnt_q;
endmodule

// File: tb/tb_async_counter.sv
// Randomized and directed checks of async_counter against a modular-arithmetic model.
module tb_async_counter;
    localparam int WIDTH = 4;
    localparam int M     = 1 << WIDTH;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             up  = 1'b0;
    logic [WIDTH-1:0] count;
    int               model = 0;
    int               errors = 0;
    int               checks = 0;

    async_counter #(.WIDTH(WIDTH)) dut (
        .up    (up),
        .clk   (clk),
        .rst   (rst),
        .count (count)
    );

    always #5 clk = ~clk;

    // Drive one edge and advance the reference model; sample 1 time unit after the edge.
    task automatic tick(input logic u, input logic r);
        up  = u;
        rst = r;
        @(posedge clk);
        #1;
        if (r)      model = 0;
        else if (u) model = (model + 1) % M;
        else        model = (model + M - 1) % M;
    endtask

    task automatic test_reset;
        for (int i = 0; i < 3; i++) begin
            tick(i[0], 1'b1);
            checks++;
            if (count !== '0) begin
                errors++;
                $display("FAIL reset[%0d]: got %0d expected 0", i, count);
            end
        end
    endtask

    task automatic test_up_wrap;
        for (int i = 0; i < 20; i++) begin
            tick(1'b1, 1'b0);
            checks++;
            if (count !== WIDTH'(model)) begin
                errors++;
                $display("FAIL up_wrap[%0d]: got %0d expected %0d", i, count, model);
            end
        end
        checks++;
        if (count !== 4'd4) begin
            errors++;
            $display("FAIL up_wrap_final: got %0d expected 4", count);
        end
    endtask

    task automatic test_down;
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b0);
        checks++;
        if (count !== 4'd15) begin
            errors++;
            $display("FAIL down_underflow: got %0d expected 15", count);
        end
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);
        checks++;
        if (count !== 4'd12) begin
            errors++;
            $display("FAIL down_3: got %0d expected 12", count);
        end
    endtask

    task automatic test_dir_switch;
        logic [WIDTH-1:0] exp_seq [3];
        logic             dir_seq [3];
        exp_seq = '{4'd6, 4'd5, 4'd6};
        dir_seq = '{1'b0, 1'b0, 1'b1};
        tick(1'b1, 1'b1);
        for (int i = 0; i < 7; i++) tick(1'b1, 1'b0);
        checks++;
        if (count !== 4'd7) begin
            errors++;
            $display("FAIL dir_up7: got %0d expected 7", count);
        end
        for (int i = 0; i < 3; i++) begin
            tick(dir_seq[i], 1'b0);
            checks++;
            if (count !== exp_seq[i]) begin
                errors++;
                $display("FAIL dir_switch[%0d]: got %0d expected %0d", i, count, exp_seq[i]);
            end
        end
    endtask

    task automatic test_mid_reset;
        tick(1'b0, 1'b1);
        for (int i = 0; i < 9; i++) tick(1'b1, 1'b0);
        checks++;
        if (count !== 4'd9) begin
            errors++;
            $display("FAIL mid_pre: got %0d expected 9", count);
        end
        tick(1'b1, 1'b1);
        checks++;
        if (count !== 4'd0) begin
            errors++;
            $display("FAIL mid_reset: got %0d expected 0", count);
        end
        for (int i = 1; i <= 2; i++) begin
            tick(1'b1, 1'b0);
            checks++;
            if (count !== WIDTH'(i)) begin
                errors++;
                $display("FAIL mid_resume[%0d]: got %0d expected %0d", i, count, i);
            end
        end
    endtask

    task automatic test_long_run;
        tick(1'b1, 1'b1);
        for (int i = 0; i < 60; i++) begin
            tick(i < 50, 1'b0);
            checks++;
            if (count !== WIDTH'(model)) begin
                errors++;
                $display("FAIL long[%0d]: got %0d expected %0d", i, count, model);
            end
            if (i == 49) begin
                checks++;
                if (count !== 4'd2) begin
                    errors++;
                    $display("FAIL long_up50: got %0d expected 2", count);
                end
            end
        end
        checks++;
        if (count !== 4'd8) begin
            errors++;
            $display("FAIL long_down10: got %0d expected 8", count);
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 300; i++) begin
            tick(1'($urandom_range(1)), ($urandom_range(19) == 0));
            checks++;
            if (count !== WIDTH'(model)) begin
                errors++;
                $display("FAIL random[%0d]: got %0d expected %0d", i, count, model);
            end
        end
    endtask

    initial begin
        test_reset();
        test_up_wrap();
        test_down();
        test_dir_switch();
        test_mid_reset();
        test_long_run();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
